// File: rtl/sct_pkg.sv
// Shared types and helpers for the sct registered counter slice.
package sct_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Terminal count for a given direction: all-ones when counting up, zero when counting down.
  function automatic logic [31:0] term_val(input logic dir, input int width);
    logic [31:0] ones;
    ones = '1;
    return dir ? (ones >> (32 - width)) : 32'd0;
  endfunction

endpackage

// File: rtl/sct_cnt_next.sv
// Combinational next-count slice: step up/down modulo 2^WIDTH, flag terminal count.
module sct_cnt_next
  import sct_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic             dir,
  input  logic             wrap,
  output logic [WIDTH-1:0] nxt,
  output logic             at_term
);

  logic [WIDTH-1:0] term;

  assign term    = WIDTH'(term_val(dir, WIDTH));
  assign at_term = (cnt == term);

  // Natural modulo arithmetic gives the wrap (max->0 up, 0->max down); stop mode holds.
  always_comb begin
    nxt = cnt;
    if (!(at_term && !wrap))
      nxt = dir ? cnt + WIDTH'(1) : cnt - WIDTH'(1);
  end

endmodule

// File: rtl/sct_counter_seq.sv
// Registered WIDTH-bit counter with clear/load/enable, up/down, wrap-or-stop,
// sequenced by an IDLE/RUN/DONE FSM. All outputs come straight from flops.
module sct_counter_seq
  import sct_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int INIT_VAL = 0
) (
  input  logic             clk_pad,
  input  logic             rst_n_pad,
  input  logic             en_pad,
  input  logic             clr_pad,
  input  logic             ld_pad,
  input  logic [WIDTH-1:0] ld_val_pad,
  input  logic             dir_pad,
  input  logic             wrap_pad,
  output logic [WIDTH-1:0] cnt_pad,
  output logic             tc_pad,
  output logic             busy_pad,
  output logic             done_pad
);

  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT_VAL);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt_d, cnt_step;
  logic             at_term, tc_d, busy_d, done_d;

  sct_cnt_next #(.WIDTH(WIDTH)) u_next (
    .cnt     (cnt_pad),
    .dir     (dir_pad),
    .wrap    (wrap_pad),
    .nxt     (cnt_step),
    .at_term (at_term)
  );

  always_ff @(posedge clk_pad or negedge rst_n_pad) begin
    if (!rst_n_pad) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // Clear beats load beats counting, in every state.
  always_comb begin
    state_nxt = state;
    cnt_d     = cnt_pad;
    tc_d      = 1'b0;
    if (clr_pad) begin
      state_nxt = ST_IDLE;
      cnt_d     = INIT_V;
    end else if (ld_pad) begin
      state_nxt = ST_IDLE;
      cnt_d     = ld_val_pad;
    end else begin
      case (state)
        ST_IDLE: if (en_pad) state_nxt = ST_RUN;
        ST_RUN: if (en_pad) begin
          cnt_d = cnt_step;
          if (at_term) begin
            tc_d = 1'b1;
            if (!wrap_pad) state_nxt = ST_DONE;
          end
        end
        ST_DONE: state_nxt = ST_DONE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_d = (state_nxt == ST_RUN);
    done_d = (state_nxt == ST_DONE);
  end

  always_ff @(posedge clk_pad or negedge rst_n_pad) begin
    if (!rst_n_pad) begin
      cnt_pad  <= INIT_V;
      tc_pad   <= 1'b0;
      busy_pad <= 1'b0;
      done_pad <= 1'b0;
    end else begin
      cnt_pad  <= cnt_d;
      tc_pad   <= tc_d;
      busy_pad <= busy_d;
      done_pad <= done_d;
    end
  end

endmodule

// File: tb/tb_sct_counter_seq.sv
// Scoreboard bench for sct_counter_seq: WIDTH=8/INIT=0 and WIDTH=4/INIT=5 instances.
module tb_sct_counter_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en, clr, ld, dir, wrap;
  logic [7:0] ldv;
  logic [7:0] cnt8;
  logic       tc8, busy8, done8;

  logic       en4, clr4, ld4, dir4, wrap4;
  logic [3:0] ldv4;
  logic [3:0] cnt4;
  logic       tc4, busy4, done4;

  sct_counter_seq #(.WIDTH(8), .INIT_VAL(0)) dut8 (
    .clk_pad(clk), .rst_n_pad(rst_n), .en_pad(en), .clr_pad(clr), .ld_pad(ld),
    .ld_val_pad(ldv), .dir_pad(dir), .wrap_pad(wrap),
    .cnt_pad(cnt8), .tc_pad(tc8), .busy_pad(busy8), .done_pad(done8)
  );

  sct_counter_seq #(.WIDTH(4), .INIT_VAL(5)) dut4 (
    .clk_pad(clk), .rst_n_pad(rst_n), .en_pad(en4), .clr_pad(clr4), .ld_pad(ld4),
    .ld_val_pad(ldv4), .dir_pad(dir4), .wrap_pad(wrap4),
    .cnt_pad(cnt4), .tc_pad(tc4), .busy_pad(busy4), .done_pad(done4)
  );

  typedef struct {
    logic [7:0] cnt;
    logic       tc, busy, done;
  } exp_t;

  exp_t sb8[$];
  exp_t sb4[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle on dut8, queue its expected response, compare after the edge.
  task automatic step8(input string tag, input logic e, c, l, input logic [7:0] v,
                       input logic d, w, input logic [7:0] ec, input logic et, eb, ed);
    exp_t x;
    en = e; clr = c; ld = l; ldv = v; dir = d; wrap = w;
    x.cnt = ec; x.tc = et; x.busy = eb; x.done = ed;
    sb8.push_back(x);
    @(posedge clk); #1;
    x = sb8.pop_front();
    chk({tag, ".cnt"},  32'(cnt8),  32'(x.cnt));
    chk({tag, ".tc"},   32'(tc8),   32'(x.tc));
    chk({tag, ".busy"}, 32'(busy8), 32'(x.busy));
    chk({tag, ".done"}, 32'(done8), 32'(x.done));
  endtask

  task automatic step4(input string tag, input logic e, c, input logic d, w,
                       input logic [3:0] ec, input logic et, eb, ed);
    exp_t x;
    en4 = e; clr4 = c; ld4 = 1'b0; ldv4 = 4'h0; dir4 = d; wrap4 = w;
    x.cnt = {4'h0, ec}; x.tc = et; x.busy = eb; x.done = ed;
    sb4.push_back(x);
    @(posedge clk); #1;
    x = sb4.pop_front();
    chk({tag, ".cnt"},  32'(cnt4),  32'(x.cnt));
    chk({tag, ".tc"},   32'(tc4),   32'(x.tc));
    chk({tag, ".busy"}, 32'(busy4), 32'(x.busy));
    chk({tag, ".done"}, 32'(done4), 32'(x.done));
  endtask

  // Independent reference for the random phase.
  logic [7:0] m_cnt;
  int         m_st;   // 0 idle, 1 run, 2 done
  logic       m_tc;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    en = 0; clr = 0; ld = 0; ldv = 0; dir = 1; wrap = 1;
    en4 = 0; clr4 = 0; ld4 = 0; ldv4 = 0; dir4 = 1; wrap4 = 1;
    #12;
    chk("rst.cnt8", 32'(cnt8), 32'h00);
    chk("rst.tc8", 32'(tc8), 0);
    chk("rst.busy8", 32'(busy8), 0);
    chk("rst.done8", 32'(done8), 0);
    chk("rst.cnt4", 32'(cnt4), 32'h5);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // WIDTH=4, INIT=5: count up from 5, wrap F->0 with tc, then clear back to 5
    step4("w4.run", 1, 0, 1, 1, 4'h5, 0, 1, 0);
    for (int i = 6; i <= 15; i++) step4("w4.up", 1, 0, 1, 1, 4'(i), 0, 1, 0);
    step4("w4.wrap", 1, 0, 1, 1, 4'h0, 1, 1, 0);
    step4("w4.post", 1, 0, 1, 1, 4'h1, 0, 1, 0);
    step4("w4.clr", 0, 1, 1, 1, 4'h5, 0, 0, 0);

    // Up-wrap from FD
    step8("t2.ld",  0, 0, 1, 8'hFD, 1, 1, 8'hFD, 0, 0, 0);
    step8("t2.idl", 0, 0, 0, 8'h00, 1, 1, 8'hFD, 0, 0, 0);
    step8("t2.run", 1, 0, 0, 8'h00, 1, 1, 8'hFD, 0, 1, 0);
    step8("t2.fe",  1, 0, 0, 8'h00, 1, 1, 8'hFE, 0, 1, 0);
    step8("t2.ff",  1, 0, 0, 8'h00, 1, 1, 8'hFF, 0, 1, 0);
    step8("t2.00",  1, 0, 0, 8'h00, 1, 1, 8'h00, 1, 1, 0);
    step8("t2.01",  1, 0, 0, 8'h00, 1, 1, 8'h01, 0, 1, 0);
    // Load while running drops back to IDLE
    step8("ldrun",  1, 0, 1, 8'h50, 1, 1, 8'h50, 0, 0, 0);

    // Stop at zero counting down, then sit in DONE
    step8("t3.ld",  0, 0, 1, 8'h02, 0, 0, 8'h02, 0, 0, 0);
    step8("t3.run", 1, 0, 0, 8'h00, 0, 0, 8'h02, 0, 1, 0);
    step8("t3.01",  1, 0, 0, 8'h00, 0, 0, 8'h01, 0, 1, 0);
    step8("t3.00",  1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0);
    step8("t3.tc",  1, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 1);
    for (int i = 0; i < 10; i++) step8("t3.hold", 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1);

    // Clear and load together in DONE: clear wins
    step8("t4.ld",  0, 0, 1, 8'hFE, 1, 0, 8'hFE, 0, 0, 0);
    step8("t4.run", 1, 0, 0, 8'h00, 1, 0, 8'hFE, 0, 1, 0);
    step8("t4.ff",  1, 0, 0, 8'h00, 1, 0, 8'hFF, 0, 1, 0);
    step8("t4.dn",  1, 0, 0, 8'h00, 1, 0, 8'hFF, 1, 0, 1);
    step8("t4.clr", 1, 1, 1, 8'hAA, 1, 0, 8'h00, 0, 0, 0);

    // Pause inside RUN
    step8("t5.ld",  0, 0, 1, 8'h10, 1, 1, 8'h10, 0, 0, 0);
    step8("t5.run", 1, 0, 0, 8'h00, 1, 1, 8'h10, 0, 1, 0);
    step8("t5.e1",  1, 0, 0, 8'h00, 1, 1, 8'h11, 0, 1, 0);
    step8("t5.e0a", 0, 0, 0, 8'h00, 1, 1, 8'h11, 0, 1, 0);
    step8("t5.e0b", 0, 0, 0, 8'h00, 1, 1, 8'h11, 0, 1, 0);
    step8("t5.e1b", 1, 0, 0, 8'h00, 1, 1, 8'h12, 0, 1, 0);

    // Direction flip at the opposite end is not terminal
    step8("dir.ld",  0, 0, 1, 8'h00, 1, 0, 8'h00, 0, 0, 0);
    step8("dir.run", 1, 0, 0, 8'h00, 1, 0, 8'h00, 0, 1, 0);
    step8("dir.up",  1, 0, 0, 8'h00, 1, 0, 8'h01, 0, 1, 0);
    step8("dir.dn",  1, 0, 0, 8'h00, 0, 1, 8'h00, 0, 1, 0);
    step8("dir.wr",  1, 0, 0, 8'h00, 0, 1, 8'hFF, 1, 1, 0);

    // Async reset mid-RUN at 37
    step8("t1.ld",  0, 0, 1, 8'h35, 1, 1, 8'h35, 0, 0, 0);
    step8("t1.run", 1, 0, 0, 8'h00, 1, 1, 8'h35, 0, 1, 0);
    step8("t1.36",  1, 0, 0, 8'h00, 1, 1, 8'h36, 0, 1, 0);
    step8("t1.37",  1, 0, 0, 8'h00, 1, 1, 8'h37, 0, 1, 0);
    rst_n = 1'b0;
    #1;
    chk("t1.cnt", 32'(cnt8), 32'h00);
    chk("t1.tc", 32'(tc8), 0);
    chk("t1.busy", 32'(busy8), 0);
    chk("t1.done", 32'(done8), 0);
    chk("t1.cnt4", 32'(cnt4), 32'h5);
    en = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    step8("t1.idl", 0, 0, 0, 8'h00, 1, 1, 8'h00, 0, 0, 0);
    step8("t1.re",  1, 0, 0, 8'h00, 1, 1, 8'h00, 0, 1, 0);

    // Random phase against the reference model, starting from a clear
    step8("rnd.clr", 0, 1, 0, 8'h00, 1, 1, 8'h00, 0, 0, 0);
    m_cnt = 8'h00; m_st = 0; m_tc = 1'b0;
    begin
      logic r_en, r_clr, r_ld, r_dir, r_wrap;
      logic [7:0] r_v, term;
      r_dir = 1'b1;
      for (int i = 0; i < 400; i++) begin
        r_en   = ($urandom_range(3) != 0);
        r_clr  = ($urandom_range(23) == 0);
        r_ld   = ($urandom_range(11) == 0);
        r_wrap = $urandom_range(1) == 1;
        if ($urandom_range(7) == 0) r_dir = ~r_dir;
        case ($urandom_range(4))
          0: r_v = 8'h00;
          1: r_v = 8'h01;
          2: r_v = 8'hFE;
          3: r_v = 8'hFF;
          default: r_v = 8'($urandom);
        endcase
        m_tc = 1'b0;
        if (r_clr) begin
          m_cnt = 8'h00; m_st = 0;
        end else if (r_ld) begin
          m_cnt = r_v; m_st = 0;
        end else if (m_st == 0) begin
          if (r_en) m_st = 1;
        end else if (m_st == 1 && r_en) begin
          term = r_dir ? 8'hFF : 8'h00;
          if (m_cnt != term) m_cnt = r_dir ? m_cnt + 8'd1 : m_cnt - 8'd1;
          else begin
            m_tc = 1'b1;
            if (r_wrap) m_cnt = r_dir ? 8'h00 : 8'hFF;
            else m_st = 2;
          end
        end
        step8("rnd", r_en, r_clr, r_ld, r_v, r_dir, r_wrap, m_cnt, m_tc,
              m_st == 1, m_st == 2);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
